// File: rtl/regfile_pkg.sv
// Shared defaults, zero constants and register-index type for the rename register file.
package regfile_pkg;

  localparam int unsigned DEF_NREG   = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_TAG_W  = 4;
  localparam int unsigned DEF_NRD    = 4;
  localparam int unsigned DEF_NCM    = 2;
  localparam int unsigned DEF_NAL    = 2;
  localparam int unsigned DEF_NCK    = 4;
  localparam int unsigned DEF_IDX_W  = $clog2(DEF_NREG);

  localparam logic [DEF_TAG_W-1:0]  ZERO_TAG  = '0;
  localparam logic [DEF_DATA_W-1:0] ZERO_DATA = '0;

  typedef logic [DEF_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_ckpt_bank.sv
// Busy/tag snapshot bank: NCK saved tables, each kept current with commit clears.
module reg_ckpt_bank
  import regfile_pkg::*;
#(
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned NCM   = DEF_NCM,
  parameter int unsigned NCK   = DEF_NCK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_ena,
  input  logic [NCM-1:0]              i_cm_vld,
  input  logic [NCM*$clog2(NREG)-1:0] i_cm_reg,
  input  logic [NCM*TAG_W-1:0]        i_cm_tag,
  input  logic                        i_save,
  input  logic [$clog2(NCK)-1:0]      i_save_id,
  input  logic [NREG-1:0]             i_save_busy,
  input  logic [NREG*TAG_W-1:0]       i_save_tag,
  input  logic [$clog2(NCK)-1:0]      i_rb_id,
  output logic [NREG-1:0]             o_rs_busy,
  output logic [NREG*TAG_W-1:0]       o_rs_tag
);

  localparam int unsigned IDX_W = $clog2(NREG);
  localparam int unsigned CK_W  = $clog2(NCK);

  logic [NREG-1:0]       r_ck_busy [NCK];
  logic [NREG*TAG_W-1:0] r_ck_tag  [NCK];
  logic [NCK-1:0]        r_ck_vld;

  logic [NREG-1:0]       w_cb [NCK];
  logic [NREG*TAG_W-1:0] w_ct [NCK];

  // Each snapshot sees the same tag-match clear rule as the live table.
  always_comb begin
    for (int unsigned k = 0; k < NCK; k++) begin
      w_cb[k] = r_ck_busy[k];
      w_ct[k] = r_ck_tag[k];
      for (int unsigned r = 1; r < NREG; r++) begin
        for (int unsigned p = 0; p < NCM; p++) begin
          if (i_ena && i_cm_vld[p] &&
              i_cm_reg[p*IDX_W +: IDX_W] == IDX_W'(r) &&
              i_cm_tag[p*TAG_W +: TAG_W] == r_ck_tag[k][r*TAG_W +: TAG_W]) begin
            w_cb[k][r]                = 1'b0;
            w_ct[k][r*TAG_W +: TAG_W] = '0;
          end
        end
      end
    end
  end

  assign o_rs_busy = w_cb[i_rb_id];
  assign o_rs_tag  = w_ct[i_rb_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ck_vld <= '0;
      for (int unsigned k = 0; k < NCK; k++) begin
        r_ck_busy[k] <= '0;
        r_ck_tag[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NCK; k++) begin
        if (i_save && i_save_id == CK_W'(k)) begin
          r_ck_busy[k] <= i_save_busy;
          r_ck_tag[k]  <= i_save_tag;
          r_ck_vld[k]  <= 1'b1;
        end else if (r_ck_vld[k]) begin
          r_ck_busy[k] <= w_cb[k];
          r_ck_tag[k]  <= w_ct[k];
        end
      end
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags, commit bypass and rollback.
// Define REG_CKPT_EN to add per-branch busy/tag checkpoints (reg_ckpt_bank).
module reg_rename_file
  import regfile_pkg::*;
#(
  parameter int unsigned NREG   = DEF_NREG,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned NRD    = DEF_NRD,
  parameter int unsigned NCM    = DEF_NCM,
  parameter int unsigned NAL    = DEF_NAL,
  parameter int unsigned NCK    = DEF_NCK
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [NRD*$clog2(NREG)-1:0] rd_idx,
  output logic [NRD*DATA_W-1:0]       rd_val,
  output logic [NRD*TAG_W-1:0]        rd_tag,
  output logic [NRD-1:0]              rd_busy,
  input  logic [NAL-1:0]              al_vld,
  input  logic [NAL*$clog2(NREG)-1:0] al_reg,
  input  logic [NAL*TAG_W-1:0]        al_tag,
  input  logic [NCM-1:0]              cm_vld,
  input  logic [NCM*$clog2(NREG)-1:0] cm_reg,
  input  logic [NCM*TAG_W-1:0]        cm_tag,
  input  logic [NCM*DATA_W-1:0]       cm_val,
  input  logic                        rollback,
  input  logic [$clog2(NCK)-1:0]      rb_id,
  input  logic                        ck_save,
  input  logic [$clog2(NCK)-1:0]      ck_id
);

  localparam int unsigned IDX_W = $clog2(NREG);

  logic [DATA_W-1:0]     r_data [NREG];
  logic [TAG_W-1:0]      r_tag  [NREG];
  logic [NREG-1:0]       r_busy;

  logic [NREG-1:0]       w_cm_wr;
  logic [NREG-1:0]       w_cm_clr;
  logic [NREG-1:0]       w_al_wr;
  logic [DATA_W-1:0]     w_cm_data [NREG];
  logic [TAG_W-1:0]      w_al_tag  [NREG];
  logic [NREG-1:0]       w_pc_busy;
  logic [NREG*TAG_W-1:0] w_pc_tag;
  logic [NREG-1:0]       w_rs_busy;
  logic [NREG*TAG_W-1:0] w_rs_tag;
  logic [NREG-1:0]       w_nx_busy;
  logic [TAG_W-1:0]      w_nx_tag [NREG];

  // Ascending port loops let the youngest (highest) port win; r0 is never decoded.
  always_comb begin
    w_cm_wr  = '0;
    w_cm_clr = '0;
    w_al_wr  = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      w_cm_data[r] = '0;
      w_al_tag[r]  = '0;
    end
    for (int unsigned r = 1; r < NREG; r++) begin
      for (int unsigned p = 0; p < NCM; p++) begin
        if (ena && cm_vld[p] && cm_reg[p*IDX_W +: IDX_W] == IDX_W'(r)) begin
          w_cm_wr[r]   = 1'b1;
          w_cm_data[r] = cm_val[p*DATA_W +: DATA_W];
          if (cm_tag[p*TAG_W +: TAG_W] == r_tag[r])
            w_cm_clr[r] = 1'b1;
        end
      end
      for (int unsigned p = 0; p < NAL; p++) begin
        if (ena && al_vld[p] && al_reg[p*IDX_W +: IDX_W] == IDX_W'(r)) begin
          w_al_wr[r]  = 1'b1;
          w_al_tag[r] = al_tag[p*TAG_W +: TAG_W];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      w_pc_busy[r]                = r_busy[r] & ~w_cm_clr[r];
      w_pc_tag[r*TAG_W +: TAG_W]  = w_cm_clr[r] ? TAG_W'(ZERO_TAG) : r_tag[r];
    end
  end

`ifdef REG_CKPT_EN
  reg_ckpt_bank #(
    .NREG  (NREG),
    .TAG_W (TAG_W),
    .NCM   (NCM),
    .NCK   (NCK)
  ) u_ckpt (
    .clk         (clk),
    .rst_n       (rst),
    .i_ena       (ena),
    .i_cm_vld    (cm_vld),
    .i_cm_reg    (cm_reg),
    .i_cm_tag    (cm_tag),
    .i_save      (ck_save & ~rollback),
    .i_save_id   (ck_id),
    .i_save_busy (w_pc_busy),
    .i_save_tag  (w_pc_tag),
    .i_rb_id     (rb_id),
    .o_rs_busy   (w_rs_busy),
    .o_rs_tag    (w_rs_tag)
  );
`else
  logic w_unused;
  assign w_unused  = ^{rb_id, ck_save, ck_id};
  assign w_rs_busy = '0;
  assign w_rs_tag  = '0;
`endif

  // Rollback overrides allocation; commit data writes proceed regardless.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rollback) begin
        w_nx_busy[r] = w_rs_busy[r];
        w_nx_tag[r]  = w_rs_tag[r*TAG_W +: TAG_W];
      end else if (w_al_wr[r]) begin
        w_nx_busy[r] = 1'b1;
        w_nx_tag[r]  = w_al_tag[r];
      end else begin
        w_nx_busy[r] = w_pc_busy[r];
        w_nx_tag[r]  = w_pc_tag[r*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        r_data[r] <= '0;
        r_tag[r]  <= '0;
      end
    end else begin
      r_busy <= w_nx_busy;
      for (int unsigned r = 0; r < NREG; r++) begin
        if (w_cm_wr[r])
          r_data[r] <= w_cm_data[r];
        r_tag[r] <= w_nx_tag[r];
      end
    end
  end

  always_comb begin
    rd_val  = '0;
    rd_tag  = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] v;
      logic [TAG_W-1:0]  t;
      logic              b;
      idx = rd_idx[i*IDX_W +: IDX_W];
      v   = r_data[idx];
      t   = r_tag[idx];
      b   = r_busy[idx];
      for (int unsigned p = 0; p < NCM; p++) begin
        if (ena && cm_vld[p] && cm_reg[p*IDX_W +: IDX_W] == idx &&
            cm_tag[p*TAG_W +: TAG_W] == r_tag[idx]) begin
          v = cm_val[p*DATA_W +: DATA_W];
          t = '0;
          b = 1'b0;
        end
      end
      if (idx == '0 || !rst) begin
        v = DATA_W'(ZERO_DATA);
        t = TAG_W'(ZERO_TAG);
        b = 1'b0;
      end
      rd_val[i*DATA_W +: DATA_W] = v;
      rd_tag[i*TAG_W +: TAG_W]   = t;
      rd_busy[i]                 = b;
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file (default parameters; REG_CKPT_EN selects the checkpoint case).
module tb_reg_rename_file;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [19:0]  rd_idx;
  logic [127:0] rd_val;
  logic [15:0]  rd_tag;
  logic [3:0]   rd_busy;
  logic [1:0]   al_vld;
  logic [9:0]   al_reg;
  logic [7:0]   al_tag;
  logic [1:0]   cm_vld;
  logic [9:0]   cm_reg;
  logic [7:0]   cm_tag;
  logic [63:0]  cm_val;
  logic         rollback;
  logic [1:0]   rb_id;
  logic         ck_save;
  logic [1:0]   ck_id;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       nm;
    logic [4:0]  idx;
    logic [31:0] val;
    logic [3:0]  tag;
    logic        busy;
  } rd_exp_t;

  rd_exp_t sb [$];

  reg_rename_file dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .rd_idx   (rd_idx),
    .rd_val   (rd_val),
    .rd_tag   (rd_tag),
    .rd_busy  (rd_busy),
    .al_vld   (al_vld),
    .al_reg   (al_reg),
    .al_tag   (al_tag),
    .cm_vld   (cm_vld),
    .cm_reg   (cm_reg),
    .cm_tag   (cm_tag),
    .cm_val   (cm_val),
    .rollback (rollback),
    .rb_id    (rb_id),
    .ck_save  (ck_save),
    .ck_id    (ck_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    al_vld   = '0;
    al_reg   = '0;
    al_tag   = '0;
    cm_vld   = '0;
    cm_reg   = '0;
    cm_tag   = '0;
    cm_val   = '0;
    rollback = 1'b0;
    rb_id    = '0;
    ck_save  = 1'b0;
    ck_id    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_al(input int p, input logic [4:0] r, input logic [3:0] t);
    al_vld[p]       = 1'b1;
    al_reg[p*5 +: 5] = r;
    al_tag[p*4 +: 4] = t;
  endtask

  task automatic set_cm(input int p, input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    cm_vld[p]         = 1'b1;
    cm_reg[p*5 +: 5]   = r;
    cm_tag[p*4 +: 4]   = t;
    cm_val[p*32 +: 32] = v;
  endtask

  task automatic exp_rd(input string nm, input logic [4:0] idx, input logic [31:0] val,
                        input logic [3:0] tag, input logic busy);
    rd_exp_t e;
    e.nm = nm; e.idx = idx; e.val = val; e.tag = tag; e.busy = busy;
    sb.push_back(e);
  endtask

  // Issue queued reads up to four at a time on the read ports, then pop and compare.
  task automatic cmp_rd();
    rd_exp_t cur [$];
    while (sb.size() > 0) begin
      cur.delete();
      while (sb.size() > 0 && cur.size() < 4) cur.push_back(sb.pop_front());
      for (int k = 0; k < cur.size(); k++) rd_idx[k*5 +: 5] = cur[k].idx;
      #1;
      for (int k = 0; k < cur.size(); k++) begin
        chk({cur[k].nm, ".val"},  rd_val[k*32 +: 32],  cur[k].val);
        chk({cur[k].nm, ".tag"},  32'(rd_tag[k*4 +: 4]), 32'(cur[k].tag));
        chk({cur[k].nm, ".busy"}, 32'(rd_busy[k]),     32'(cur[k].busy));
      end
    end
  endtask

  initial begin
    rst    = 1'b0;
    ena    = 1'b1;
    rd_idx = '0;
    idle();
    #2;
    exp_rd("rst_r0", 0, 0, 0, 0);
    exp_rd("rst_r5", 5, 0, 0, 0);
    exp_rd("rst_r31", 31, 0, 0, 0);
    cmp_rd();
    @(negedge clk);
    rst = 1'b1;
    tick();

    set_al(0, 5, 3);
    exp_rd("al_hidden", 5, 0, 0, 0);
    cmp_rd();
    tick();
    exp_rd("al_r5", 5, 0, 3, 1);
    cmp_rd();
    set_cm(0, 5, 3, 32'hAA);
    exp_rd("cm_byp_r5", 5, 32'hAA, 0, 0);
    cmp_rd();
    tick();
    exp_rd("cm_r5", 5, 32'hAA, 0, 0);
    cmp_rd();

    set_al(0, 5, 3);
    tick();
    set_al(1, 5, 7);
    tick();
    set_cm(0, 5, 3, 32'h11);
    exp_rd("stale_byp_r5", 5, 32'hAA, 7, 1);
    cmp_rd();
    tick();
    exp_rd("stale_r5", 5, 32'h11, 7, 1);
    cmp_rd();

    set_cm(1, 5, 7, 32'h22);
    set_al(0, 5, 9);
    exp_rd("alcm_byp_r5", 5, 32'h22, 0, 0);
    cmp_rd();
    tick();
    exp_rd("alcm_r5", 5, 32'h22, 9, 1);
    cmp_rd();

    set_al(1, 2, 4);
    tick();
    set_cm(1, 2, 4, 32'h55);
    exp_rd("byp_r2", 2, 32'h55, 0, 0);
    exp_rd("byp_r5", 5, 32'h22, 9, 1);
    cmp_rd();
    tick();
    exp_rd("cm_r2", 2, 32'h55, 0, 0);
    cmp_rd();

    set_al(0, 9, 1);
    set_al(1, 9, 2);
    tick();
    exp_rd("al_young_r9", 9, 0, 2, 1);
    cmp_rd();
    set_al(0, 0, 6);
    set_cm(0, 0, 0, 32'h77);
    exp_rd("byp_r0", 0, 0, 0, 0);
    cmp_rd();
    tick();
    exp_rd("wr_r0", 0, 0, 0, 0);
    cmp_rd();

    set_cm(0, 3, 0, 32'h33);
    set_cm(1, 3, 0, 32'h44);
    exp_rd("cmpri_byp_r3", 3, 32'h44, 0, 0);
    cmp_rd();
    tick();
    exp_rd("cmpri_r3", 3, 32'h44, 0, 0);
    cmp_rd();

    ena = 1'b0;
    set_al(0, 7, 5);
    set_cm(0, 9, 2, 32'h99);
    exp_rd("ena_byp_r9", 9, 0, 2, 1);
    cmp_rd();
    tick();
    ena = 1'b1;
    exp_rd("ena_r7", 7, 0, 0, 0);
    exp_rd("ena_r9", 9, 0, 2, 1);
    cmp_rd();

`ifndef REG_CKPT_EN
    rollback = 1'b1;
    set_al(0, 11, 3);
    set_cm(0, 9, 1, 32'h5A);
    exp_rd("rb_pre_r9", 9, 0, 2, 1);
    cmp_rd();
    tick();
    exp_rd("rb_r5", 5, 32'h22, 0, 0);
    exp_rd("rb_r9", 9, 32'h5A, 0, 0);
    exp_rd("rb_r11", 11, 0, 0, 0);
    exp_rd("rb_r2", 2, 32'h55, 0, 0);
    cmp_rd();
`else
    set_al(0, 4, 2);
    tick();
    ck_save = 1'b1;
    ck_id   = 2'd1;
    set_al(0, 6, 5);
    tick();
    exp_rd("ck_r6", 6, 0, 5, 1);
    exp_rd("ck_r4", 4, 0, 2, 1);
    cmp_rd();
    set_cm(0, 4, 2, 32'h42);
    tick();
    rollback = 1'b1;
    rb_id    = 2'd1;
    tick();
    exp_rd("ckrb_r4", 4, 32'h42, 0, 0);
    exp_rd("ckrb_r6", 6, 0, 0, 0);
    exp_rd("ckrb_r5", 5, 32'h22, 9, 1);
    exp_rd("ckrb_r9", 9, 0, 2, 1);
    cmp_rd();
`endif

    set_al(0, 12, 3);
    set_cm(0, 3, 0, 32'h66);
    ena = 1'b1;
    rst = 1'b0;
    #1;
    exp_rd("arst_r3", 3, 0, 0, 0);
    exp_rd("arst_r5", 5, 0, 0, 0);
    exp_rd("arst_r2", 2, 0, 0, 0);
    exp_rd("arst_r9", 9, 0, 0, 0);
    cmp_rd();
    @(posedge clk);
    #1;
    exp_rd("arst_edge_r12", 12, 0, 0, 0);
    cmp_rd();
    @(negedge clk);
    idle();
    rst = 1'b1;
    tick();
    exp_rd("post_r12", 12, 0, 0, 0);
    exp_rd("post_r3", 3, 0, 0, 0);
    exp_rd("post_r5", 5, 0, 0, 0);
    cmp_rd();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
